// File: rtl/unsigned_seq_divider_16by8_pkg.sv
// Shared definitions for the 16-by-8 unsigned sequential divider.
//   DIV_W        : default divisor/remainder width
//   div_state_t  : controller states (IDLE, CALC, DONE)
//   cnt_width()  : width of the step counter for a given W
//   DBZ_QUOTIENT : quotient reported for a zero divisor (all ones)
package unsigned_seq_divider_16by8_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The counter must hold the value 2W, hence 2W+1 distinct values.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIV_W);

    localparam logic [2*DIV_W-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/unsigned_seq_divider_16by8_if.sv
// Operand/result handshake bundle for the sequential divider.
//   in_valid/in_ready   : operand handshake, carries dividend (2W) and divisor (W)
//   out_valid/out_ready : result handshake, carries quotient (2W), remainder (W),
//                         div_by_zero
// master = operand source and result consumer, slave = divider.
interface unsigned_seq_divider_16by8_if
    import unsigned_seq_divider_16by8_pkg::*;
#(
    parameter int W = DIV_W
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/unsigned_seq_divider_16by8_div_restoring_step.sv
// One radix-2 restoring division step (purely combinational).
//   pr_in    : current partial remainder (always < divisor, so W bits suffice)
//   next_bit : next dividend bit, MSB first
//   divisor  : divisor
//   pr_out   : updated partial remainder
//   q_bit    : resulting quotient bit
module div_restoring_step
    import unsigned_seq_divider_16by8_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] pr_in,
    input  logic         next_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] pr_out,
    output logic         q_bit
);
    logic [W:0]   trial;
    logic [W-1:0] diff;

    always_comb begin
        trial  = {pr_in, next_bit};
        q_bit  = (trial >= {1'b0, divisor});
        // When the subtraction is taken the result is below the divisor,
        // so the low W bits of the difference are exact.
        diff   = trial[W-1:0] - divisor;
        pr_out = q_bit ? diff : trial[W-1:0];
    end
endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Iterative radix-2 restoring divider: 2W-bit dividend / W-bit divisor.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of unsigned_seq_divider_16by8_if
//                (operand handshake in, result handshake out)
// Parameters: W (divisor width), APPROX_L (low quotient bits skipped in
// approximate mode, legal 0..2W-1).
// Build option: define APPROX_DIV_EN to run only 2W-APPROX_L steps; the
// quotient then has its low APPROX_L bits cleared and the remainder is 0.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | one quotient bit per cycle, MSB first
// DONE  | out_valid high, result held until out_ready
module unsigned_seq_divider_16by8
    import unsigned_seq_divider_16by8_pkg::*;
#(
    parameter int W        = DIV_W,
    parameter int APPROX_L = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    unsigned_seq_divider_16by8_if.slave   bus
);
    localparam int CW = cnt_width(W);

`ifdef APPROX_DIV_EN
    localparam int STEPS = 2 * W - APPROX_L;
`else
    localparam int STEPS = 2 * W;
`endif

    localparam logic [CW-1:0] STEPS_CNT = CW'(STEPS);

    if (APPROX_L < 0 || APPROX_L > 2 * W - 1) begin : g_bad_approx_l
        $error("APPROX_L must lie in 0..2W-1");
    end

    div_state_t     state;
    logic [2*W-1:0] q_reg;      // dividend bits shift out the top, quotient bits in the bottom
    logic [W-1:0]   rem_reg;
    logic [W-1:0]   dvs_reg;
    logic [CW-1:0]  cnt;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           dbz_r;

    logic [W-1:0]   pr_next;
    logic           q_bit;
    logic [2*W-1:0] q_next;

    div_restoring_step #(.W(W)) u_step (
        .pr_in    (rem_reg),
        .next_bit (q_reg[2*W-1]),
        .divisor  (dvs_reg),
        .pr_out   (pr_next),
        .q_bit    (q_bit)
    );

    assign q_next = {q_reg[2*W-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            q_reg       <= '0;
            rem_reg     <= '0;
            dvs_reg     <= '0;
            dbz_r       <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        dvs_reg    <= bus.divisor;
                        in_ready_r <= 1'b0;
                        if (bus.divisor == '0) begin
                            q_reg       <= '1;
                            rem_reg     <= bus.dividend[W-1:0];
                            dbz_r       <= 1'b1;
                            cnt         <= '0;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q_reg   <= bus.dividend;
                            rem_reg <= '0;
                            dbz_r   <= 1'b0;
                            cnt     <= STEPS_CNT;
                            state   <= CALC;
                        end
                    end
                end

                CALC: begin
                    cnt     <= cnt - 1'b1;
                    q_reg   <= q_next;
                    rem_reg <= pr_next;
                    if (cnt == CW'(1)) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
`ifdef APPROX_DIV_EN
                        // Only the upper quotient bits were produced; move
                        // them into place and drop the partial remainder.
                        q_reg   <= q_next << APPROX_L;
                        rem_reg <= '0;
`endif
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = q_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Self-checking bench for unsigned_seq_divider_16by8: directed cases, a
// mid-division reset, and a back-to-back random run against a plain
// arithmetic reference model.
module tb_unsigned_seq_divider_16by8;

    localparam int W    = 8;
    localparam int AL   = 4;
    localparam int NOPS = 2000;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    unsigned_seq_divider_16by8_if #(.W(W)) bus ();

    unsigned_seq_divider_16by8 #(.W(W), .APPROX_L(AL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t        e;
        int unsigned au;
        int unsigned bu;
        au = a;
        bu = b;
        if (bu == 0) begin
            e.q   = 16'hFFFF;
            e.r   = a[7:0];
            e.dbz = 1'b1;
            e.lat = 8'd1;
        end else begin
            e.dbz = 1'b0;
`ifdef APPROX_DIV_EN
            e.q   = 16'((au / (bu << AL)) << AL);
            e.r   = 8'd0;
            e.lat = 8'(2 * W - AL + 1);
`else
            e.q   = 16'(au / bu);
            e.r   = 8'(au % bu);
            e.lat = 8'(2 * W + 1);
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One operand/result transaction with the consumer stalling for hold cycles.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold, input string tag);
        exp_t e;
        int   lat;
        e = model(a, b);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            chk({tag, ".hold_q"}, 32'(bus.quotient), 32'(e.q));
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        chk({tag, ".quotient"}, 32'(bus.quotient), 32'(e.q));
        chk({tag, ".remainder"}, 32'(bus.remainder), 32'(e.r));
        chk({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        exp_t        exp_q[$];
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          n_acc;
        int          n_done;
        int          last_acc;
        int          last_lat;
        bit          new_ops;
        logic [15:0] ra;
        logic [7:0]  rb;

        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.quotient", 32'(bus.quotient), 32'd0);
        chk("reset.remainder", 32'(bus.remainder), 32'd0);
        chk("reset.dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;

        run_op(16'd65025, 8'd255, 0, "sq255");
        run_op(16'd1000, 8'd7, 5, "k1000_7");
        run_op(16'h1234, 8'd0, 2, "dbz");
        run_op(16'd0, 8'd37, 0, "zero_dividend");
        run_op(16'd50, 8'd200, 0, "small_dividend");
        run_op(16'd54321, 8'd1, 0, "div_one");
        run_op(16'd65535, 8'd255, 1, "max");

        // Reset in the middle of a division.
        @(negedge clk);
        bus.dividend = 16'd65535;
        bus.divisor  = 8'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midreset.no_result", 32'(bus.out_valid), 32'd0);
        run_op(16'd100, 8'd10, 0, "after_reset");

        // Back-to-back random operands, consumer always ready.
        bus.out_ready = 1'b1;
        cyc      = 0;
        n_acc    = 0;
        n_done   = 0;
        last_acc = -1;
        last_lat = 0;
        new_ops  = 1'b1;
        while (n_done < NOPS && cyc < 90000) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                if (exp_q.size() > 0) begin
                    e   = exp_q.pop_front();
                    got = '0;
                    chk("rand.quotient", 32'(bus.quotient), 32'(e.q));
                    chk("rand.remainder", 32'(bus.remainder), 32'(e.r));
                    chk("rand.dbz", 32'(bus.div_by_zero), 32'(e.dbz));
                end else begin
                    chk("rand.spurious_result", 32'(bus.out_valid), 32'd0);
                end
                n_done++;
            end
            if (new_ops) begin
                if (n_acc < NOPS) begin
                    ra = 16'($urandom_range(0, 65535));
                    rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                    bus.dividend = ra;
                    bus.divisor  = rb;
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
                new_ops = 1'b0;
            end
            if (bus.in_ready && bus.in_valid) begin
                e = model(bus.dividend, bus.divisor);
                exp_q.push_back(e);
                if (last_acc >= 0) begin
                    chk("rand.accept_spacing", 32'(cyc - last_acc), 32'(last_lat + 1));
                end
                last_acc = cyc;
                last_lat = int'(e.lat);
                n_acc++;
                new_ops = 1'b1;
            end
        end
        chk("rand.completed", 32'(n_done), 32'(NOPS));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
